// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder stage.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ADDER_HALF = 0;
    localparam int ADDER_FULL = 1;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder cell driven serially by serial_adder.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder
// cell with a carry flop; result is presented on a valid/ready output.
module serial_adder #(
    parameter int WIDTH      = 8,
    parameter int ADDER_TYPE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    import serial_adder_pkg::*;

    // One extra counter bit keeps WIDTH-1 representable for every legal WIDTH.
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_next;
    logic [WIDTH-1:0] sum_sh_next;
    logic             bit_s;
    logic             bit_co;
    logic             load_carry;

    serial_fa_cell u_cell (
        .a  (a_sh_reg[0]),
        .b  (b_sh_reg[0]),
        .ci (carry_reg),
        .s  (bit_s),
        .co (bit_co)
    );

    // Per-bit shift networks; written bitwise so WIDTH=1 needs no empty slice.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign a_sh_next[gi]   = 1'b0;
                assign b_sh_next[gi]   = 1'b0;
                assign sum_sh_next[gi] = bit_s;
            end else begin : g_mid
                assign a_sh_next[gi]   = a_sh_reg[gi+1];
                assign b_sh_next[gi]   = b_sh_reg[gi+1];
                assign sum_sh_next[gi] = sum_sh_reg[gi+1];
            end
        end
    endgenerate

    assign load_carry = (ADDER_TYPE == ADDER_FULL) ? cin : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        sum_sh_reg   <= '0;
                        carry_reg    <= load_carry;
                        cnt_reg      <= '0;
                        state_reg    <= SHIFT;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_next;
                    b_sh_reg   <= b_sh_next;
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= bit_co;
                    cnt_reg    <= cnt_reg + ONE;
                    if (cnt_reg == LAST) begin
                        sum_reg       <= sum_sh_next;
                        cout_reg      <= bit_co;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: full-adder WIDTH=8, half-adder WIDTH=8
// and full-adder WIDTH=1 instances sharing one clock and reset.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, full-adder mode
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    serial_adder #(.WIDTH(8), .ADDER_TYPE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    // Half-adder instance: WIDTH=8, cin ignored
    logic       h_in_valid = 1'b0;
    logic       h_in_ready;
    logic [7:0] h_a = '0;
    logic [7:0] h_b = '0;
    logic       h_cin = 1'b0;
    logic       h_out_valid;
    logic       h_out_ready = 1'b1;
    logic [7:0] h_sum;
    logic       h_cout;
    logic       h_busy;

    serial_adder #(.WIDTH(8), .ADDER_TYPE(0)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cin(h_cin), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .sum(h_sum), .cout(h_cout), .busy(h_busy)
    );

    // Single-bit instance
    logic       w_in_valid = 1'b0;
    logic       w_in_ready;
    logic [0:0] w_a = '0;
    logic [0:0] w_b = '0;
    logic       w_cin = 1'b0;
    logic       w_out_valid;
    logic       w_out_ready = 1'b1;
    logic [0:0] w_sum;
    logic       w_cout;
    logic       w_busy;

    serial_adder #(.WIDTH(1), .ADDER_TYPE(1)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .busy(w_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge k; ends just after edge k+8.
    task automatic run_to_done(input string tag, input logic [7:0] exp_sum, input logic exp_cout);
        chk({tag, ":busy_k"}, 64'(busy), 64'd1);
        chk({tag, ":in_ready_k"}, 64'(in_ready), 64'd0);
        for (int j = 1; j < 8; j++) begin
            step();
            chk({tag, ":out_valid_early"}, 64'(out_valid), 64'd0);
            chk({tag, ":in_ready_shift"}, 64'(in_ready), 64'd0);
        end
        step();
        chk({tag, ":out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ":in_ready_done"}, 64'(in_ready), 64'd0);
        chk({tag, ":sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, ":cout"}, 64'(cout), 64'(exp_cout));
        $display("[TB] %s: sum=0x%02h cout=%0d (expect 0x%02h/%0d)", tag, sum, cout, exp_sum, exp_cout);
    endtask

    task automatic op(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc);
        logic [8:0] total;
        total = 9'(va) + 9'(vb) + 9'(vc);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        run_to_done(tag, total[7:0], total[8]);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ":in_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, ":out_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    logic [7:0] ra, rb;
    logic       rc;
    logic [7:0] ha_v [3] = '{8'h0F, 8'hFF, 8'h80};
    logic [7:0] hb_v [3] = '{8'h01, 8'h01, 8'h80};
    logic [7:0] hs_v [3] = '{8'h10, 8'h00, 8'h00};
    logic       hc_v [3] = '{1'b0, 1'b1, 1'b1};
    logic       wa_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       wb_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       wc_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        step();
        step();
        chk("rst:in_ready", 64'(in_ready), 64'd1);
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:sum", 64'(sum), 64'd0);
        chk("rst:cout", 64'(cout), 64'd0);
        rst = 1'b0;
        step();

        op("ff_plus_01", 8'hFF, 8'h01, 1'b0);
        op("7f_80_cin", 8'h7F, 8'h80, 1'b1);
        op("zero", 8'h00, 8'h00, 1'b0);
        op("cin_only", 8'h00, 8'h00, 1'b1);
        op("aa_55", 8'hAA, 8'h55, 1'b0);

        // Backpressure: result held while a second operand waits on in_valid.
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 8'h01; b = 8'h01; cin = 1'b0;
        run_to_done("bp_first", 8'h46, 1'b0);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("bp:out_valid_hold", 64'(out_valid), 64'd1);
            chk("bp:in_ready_hold", 64'(in_ready), 64'd0);
            chk("bp:sum_hold", 64'(sum), 64'h46);
            chk("bp:cout_hold", 64'(cout), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp:in_ready_release", 64'(in_ready), 64'd1);
        chk("bp:out_valid_release", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        run_to_done("bp_second", 8'h02, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during the third SHIFT cycle drops the operation.
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst:out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst:in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst:busy", 64'(busy), 64'd0);
        chk("mid_rst:sum", 64'(sum), 64'd0);
        chk("mid_rst:cout", 64'(cout), 64'd0);
        for (int j = 0; j < 10; j++) begin
            step();
            chk("mid_rst:no_pulse", 64'(out_valid), 64'd0);
        end
        op("after_rst", 8'h03, 8'h04, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            op("rand", ra, rb, rc);
            repeat ($urandom_range(0, 3)) step();
        end

        // Half-adder mode: cin must never reach the first bit.
        for (int i = 0; i < 3; i++) begin
            h_a = ha_v[i]; h_b = hb_v[i]; h_cin = 1'b1; h_in_valid = 1'b1;
            chk("half:in_ready", 64'(h_in_ready), 64'd1);
            step();
            h_in_valid = 1'b0;
            repeat (8) step();
            chk("half:out_valid", 64'(h_out_valid), 64'd1);
            chk("half:sum", 64'(h_sum), 64'(hs_v[i]));
            chk("half:cout", 64'(h_cout), 64'(hc_v[i]));
            $display("[TB] half: 0x%02h+0x%02h sum=0x%02h cout=%0d (expect 0x%02h/%0d)",
                     ha_v[i], hb_v[i], h_sum, h_cout, hs_v[i], hc_v[i]);
            step();
        end

        // WIDTH=1: result one edge after acceptance.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] t;
            t = 2'(wa_v[i]) + 2'(wb_v[i]) + 2'(wc_v[i]);
            w_a = wa_v[i]; w_b = wb_v[i]; w_cin = wc_v[i]; w_in_valid = 1'b1;
            chk("w1:in_ready", 64'(w_in_ready), 64'd1);
            step();
            w_in_valid = 1'b0;
            chk("w1:busy", 64'(w_busy), 64'd1);
            chk("w1:out_valid_early", 64'(w_out_valid), 64'd0);
            step();
            chk("w1:out_valid", 64'(w_out_valid), 64'd1);
            chk("w1:sum", 64'(w_sum), 64'(t[0]));
            chk("w1:cout", 64'(w_cout), 64'(t[1]));
            $display("[TB] w1: %0d+%0d+%0d sum=%0d cout=%0d", wa_v[i], wb_v[i], wc_v[i], w_sum, w_cout);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder stage built around a 1-bit full-adder cell plus a carry flop.
- It accepts a pair of operands through a valid/ready handshake and shifts them LSB-first through the cell, one bit per clock.
- It presents the assembled sum and carry-out on a valid/ready output.
- It is the sequencing stage that drives a single adder cell with operand bits. This replaces a wide parallel adder where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- ADDER_TYPE, 1, 0 = half-adder mode (cin forced to 0 at load); 1 = full-adder mode (cin port used).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when ADDER_TYPE=0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH.
- cout  output  1  carry-out of bit WIDTH-1.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst is synchronous and active-high.
  - While rst is high at a rising edge: state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; carry=0; bit counter=0; operand shift registers=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: load a_sh=a, b_sh=b; carry=(ADDER_TYPE ? cin : 0); cnt=0; go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge:
    - s = a_sh[0]^b_sh[0]^carry.
    - carry = majority(a_sh[0], b_sh[0], carry).
    - sum_sh = {s, sum_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right with 0 fill.
    - cnt++.
  - On the edge where cnt==WIDTH-1 (after WIDTH shift cycles): go to DONE.
  - On that same edge, register sum=final sum_sh and cout=final carry.
- DONE:
  - out_valid=1; sum and cout held stable.
  - in_ready=0; in_valid is ignored.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - sum and cout keep their last value until the next result; they are only meaningful while out_valid=1.
- Latency and throughput:
  - Accept at edge k gives out_valid=1 after edge k+WIDTH.
  - With out_ready held high, in_ready returns to 1 after edge k+WIDTH+1.
  - Throughput is one operation per WIDTH+2 cycles.
  - No overlap: a new operand is never accepted while busy.
- WIDTH=1: exactly one SHIFT cycle.
- Counter width is $clog2(WIDTH)+1 bits, so there is no wrap for any legal WIDTH.
- Reset mid-operation (SHIFT or DONE):
  - The in-flight operation is dropped; no out_valid pulse is produced.
  - All registers take their reset values on that edge.
- Arithmetic:
  - Unsigned; sum width equals WIDTH; the overflow bit appears only on cout.
  - In ADDER_TYPE=0 the first bit uses carry=0 regardless of cin.
- Combinational paths:
  - None from inputs to outputs.
  - in_ready, out_valid and busy are decoded from state only.

Decomposition:
- Package serial_adder_pkg contains:
  - State typedef: enum {IDLE, SHIFT, DONE}.
  - Constants ADDER_HALF=0 and ADDER_FULL=1 for ADDER_TYPE.
- Sub-module serial_fa_cell: combinational 1-bit full adder with ports a, b, ci, s, co.
- The carry flop, counter, shift registers and FSM stay in serial_adder.

Test Plan:
- WIDTH=8, ADDER_TYPE=1, accept a=0xFF, b=0x01, cin=0 at edge k -> out_valid rises after edge k+8; sum=0x00, cout=1; in_ready=0 during edges k+1..k+8.
- WIDTH=8, ADDER_TYPE=0, a=0x0F, b=0x01, cin=1 -> sum=0x10, cout=0 (cin ignored).
- WIDTH=8, ADDER_TYPE=1, a=0x7F, b=0x80, cin=1 -> sum=0x00, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum/cout stable, in_ready=0, second operand not taken; after out_ready=1, in_ready=1 on the next cycle and the second op completes correctly.
- Assert rst during the 3rd SHIFT cycle of a=0xAA, b=0x55 -> next cycle state IDLE, out_valid=0, sum=0, cout=0; a following op 0x03+0x04 gives sum=0x07, cout=0.
- 1000 random ops for WIDTH in {1, 8, 13}, with random in_valid/out_ready gaps -> every result equals a+b+cin (cin masked in mode 0), one output per accepted input, in order.
